// File: rtl/uart_pkg.sv
// Shared types and constants for the task UART drain stage.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic                      last;
    logic [UART_DATA_BITS-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/task_uart_tx_drain_if.sv
// Byte stream from the task stage: data/valid/last, no backpressure.
interface task_uart_tx_drain_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  last;

  modport master (output data, output valid, output last);
  modport slave  (input  data, input  valid, input  last);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full/empty/level derived from the registered occupancy.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             wr, rd;

  // A pop in the same cycle never frees a slot for a write: full is pre-edge.
  assign o_full    = (level_q == LW'(DEPTH));
  assign o_empty   = (level_q == '0);
  assign o_level   = level_q;
  assign o_rd_data = mem_q[rd_ptr_q];
  assign wr        = i_wr_en && !o_full;
  assign rd        = i_rd_en && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr, rd})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/task_uart_tx_drain.sv
// Buffers the task byte stream and serialises it as 8N1 on o_tx.
module task_uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  task_uart_tx_drain_if.slave  in_if,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic                 o_frame_done,
  output logic [LW-1:0]        o_level
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  tx_state_t                 state_q, state_d;
  logic [CW-1:0]             baud_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      last_q, frame_done_q, overflow_q;
  logic                      baud_end, pop, fifo_full, fifo_empty;
  fifo_entry_t               wr_entry, rd_entry;

  assign wr_entry = '{last: in_if.last, data: in_if.data};
  assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (in_if.valid),
    .i_wr_data(wr_entry),
    .i_rd_en  (pop),
    .o_rd_data(rd_entry),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty),
    .o_level  (o_level)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (baud_end) state_d = DATA;
      DATA:  if (baud_end && bit_idx_q == 3'd7) state_d = STOP;
      STOP:  if (baud_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tx = 1'b1;
    unique case (state_q)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shift_q[0];
      default: o_tx = 1'b1;
    endcase
    // Pop from IDLE or on the last STOP cycle so back-to-back bytes leave no gap.
    pop    = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
    o_busy = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= (state_q == STOP) && baud_end && last_q;
      overflow_q   <= overflow_q | (in_if.valid & fifo_full);
      if ((state_q == IDLE) || baud_end) baud_q <= '0;
      else                               baud_q <= baud_q + CW'(1);
      if (pop) begin
        shift_q   <= rd_entry.data;
        last_q    <= rd_entry.last;
        bit_idx_q <= '0;
      end else if ((state_q == DATA) && baud_end) begin
        shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

  assign o_overflow   = overflow_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_task_uart_tx_drain.sv
// Scoreboard bench: expected {last,byte} queued at issue, serial monitor decodes and compares.
module tb_task_uart_tx_drain;

  logic       clk, rst_n;
  logic       tx, busy, overflow, fd;
  logic [2:0] level;

  task_uart_tx_drain_if #(.DATA_WIDTH(8)) bus ();

  task_uart_tx_drain #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .in_if       (bus),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_overflow  (overflow),
    .o_frame_done(fd),
    .o_level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, frames_seen = 0, fd_count = 0, lvl_max = 0;
  logic [8:0]  exp_q[$];
  int          start_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (fd === 1'b1) fd_count++;
    if (int'(level) > lvl_max) lvl_max = int'(level);
  end

  // Serial monitor: one negedge sample per clock, 4 samples per bit cell.
  initial begin : monitor
    logic [8:0] exp;
    logic [7:0] got;
    logic       bad, aborted, carry, eb;
    carry = 1'b0;
    forever begin
      if (!carry) @(negedge clk);
      carry = 1'b0;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          exp = '0;
        end else begin
          exp = exp_q.pop_front();
        end
        bad = 1'b0; aborted = 1'b0; got = '0;
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          eb = (k < 4) ? 1'b0 : (k < 36) ? exp[(k - 4) / 4] : 1'b1;
          if (tx !== eb) bad = 1'b1;
          if (k >= 4 && k < 36 && (k % 4) == 2) got[(k - 4) / 4] = tx;
        end
        if (!aborted) begin
          chk("frame_byte", {24'd0, got}, {24'd0, exp[7:0]});
          chk("frame_shape", {31'd0, bad}, 32'd0);
          @(negedge clk);
          if (rst_n === 1'b1) begin
            chk("frame_done_pulse", {31'd0, fd}, {31'd0, exp[8]});
            frames_seen++;
            carry = (tx === 1'b0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic l);
    bus.valid = 1'b1; bus.data = d; bus.last = l;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.last = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("idle_wait_timeout", n, max - 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  int   fd0, f0, s0;
  logic bad_idle;

  initial begin
    rst_n = 1'b0; bus.valid = 1'b0; bus.data = '0; bus.last = 1'b0;
    #3;
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_frame_done", {31'd0, fd}, 0);
    chk("rst_level", {29'd0, level}, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Idle line for 100 cycles
    bad_idle = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) bad_idle = 1'b1;
    end
    chk("idle_100", {31'd0, bad_idle}, 0);
    @(posedge clk); #1;

    // Single byte A5 with last
    fd0 = fd_count; f0 = frames_seen;
    exp_q.push_back({1'b1, 8'hA5});
    send(8'hA5, 1'b1);
    wait_idle(200);
    chk("s1_frames", frames_seen - f0, 1);
    chk("s1_fd_count", fd_count - fd0, 1);
    chk("s1_busy_after", {31'd0, busy}, 0);

    // Three back-to-back bytes
    fd0 = fd_count; f0 = frames_seen; s0 = start_cyc.size();
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'h03});
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
    wait_idle(400);
    chk("s2_frames", frames_seen - f0, 3);
    chk("s2_fd_count", fd_count - fd0, 1);
    if (start_cyc.size() >= s0 + 3) begin
      chk("s2_gap01", start_cyc[s0 + 1] - start_cyc[s0], 40);
      chk("s2_gap12", start_cyc[s0 + 2] - start_cyc[s0 + 1], 40);
    end else begin
      chk("s2_start_count", start_cyc.size() - s0, 3);
    end

    // Write landing on the final STOP cycle with an empty FIFO
    fd0 = fd_count; s0 = start_cyc.size();
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b1, 8'hC3});
    send(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    send(8'hC3, 1'b1);
    wait_idle(300);
    chk("s6_fd_count", fd_count - fd0, 1);
    if (start_cyc.size() >= s0 + 2) chk("s6_gap", start_cyc[s0 + 1] - start_cyc[s0], 41);
    else chk("s6_start_count", start_cyc.size() - s0, 2);

    // Overflow: six writes into depth 4, 0x15 dropped
    fd0 = fd_count; f0 = frames_seen; lvl_max = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0);
    chk("s3_ovf_before", {31'd0, overflow}, 0);
    send(8'h15, 1'b0);
    chk("s3_ovf_after", {31'd0, overflow}, 1);
    chk("s3_level_full", {29'd0, level}, 4);
    wait_idle(400);
    chk("s3_ovf_sticky", {31'd0, overflow}, 1);
    chk("s3_level_peak", lvl_max, 4);
    chk("s3_frames", frames_seen - f0, 5);
    chk("s3_fd_count", fd_count - fd0, 0);

    rst_n = 1'b0;
    #2;
    chk("rst_clears_ovf", {31'd0, overflow}, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Reset during DATA bit 3 of 0x5A with two bytes queued
    exp_q.push_back({1'b0, 8'h5A});
    send(8'h5A, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b1);
    repeat (15) @(posedge clk);
    #3;
    chk("s4_level_pre", {29'd0, level}, 2);
    chk("s4_busy_pre", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("s4_async_tx", {31'd0, tx}, 1);
    chk("s4_async_level", {29'd0, level}, 0);
    chk("s4_async_busy", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    fd0 = fd_count; f0 = frames_seen;
    bad_idle = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad_idle = 1'b1;
    end
    chk("s4_line_idle", {31'd0, bad_idle}, 0);
    chk("s4_no_fd", fd_count - fd0, 0);
    chk("s4_no_frames", frames_seen - f0, 0);
    chk("s4_ovf", {31'd0, overflow}, 0);
    chk("s4_level", {29'd0, level}, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
